// File: rtl/conv_result_streamer.sv
// Captures the flattened convolution result on the completion edge and streams
// it out one 16-bit sample per accepted beat over a valid/ready handshake.
module conv_result_streamer #(
   parameter  int unsigned LEN             = 19,
   parameter  int unsigned SIGNAL_LENGTH_1 = 2400,
   parameter  int unsigned IDX_W           = 12,
   localparam int unsigned N_OUT           = LEN + SIGNAL_LENGTH_1 + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               is_completed,
   input  logic [N_OUT*16:0]  flatten_conv_result,
   output logic [15:0]        m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [IDX_W-1:0]   m_index,
   output logic               m_last,
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   localparam int unsigned   SAMPLE_W = 16;
   localparam int unsigned   BUF_W    = N_OUT * SAMPLE_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               is_completed_q;
   logic               start_c;
   logic               xfer_c;
   logic               load_c;
   logic               shift_c;
   logic [BUF_W-1:0]   buf_q;
   logic [BUF_W-1:0]   buf_shift_c;

   logic [15:0]        data_nxt;
   logic               valid_nxt;
   logic [IDX_W-1:0]   index_nxt;
   logic               last_nxt;
   logic               busy_nxt;
   logic               done_nxt;
   logic               overrun_nxt;

   // The top bit of the result bus carries nothing.
   logic               unused_msb;
   assign unused_msb = flatten_conv_result[BUF_W];

   assign start_c     = is_completed & ~is_completed_q;
   assign xfer_c      = m_valid & m_ready;
   assign buf_shift_c = buf_q >> SAMPLE_W;

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         is_completed_q <= 1'b0;
         m_data         <= '0;
         m_valid        <= 1'b0;
         m_index        <= '0;
         m_last         <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         state          <= state_nxt;
         is_completed_q <= is_completed;
         m_data         <= data_nxt;
         m_valid        <= valid_nxt;
         m_index        <= index_nxt;
         m_last         <= last_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         overrun        <= overrun_nxt;
      end
   end

   // Sample buffer: bits [15:0] always hold the sample currently presented.
   always_ff @(posedge clk) begin
      if (load_c) begin
         buf_q <= flatten_conv_result[BUF_W-1:0];
      end else if (shift_c) begin
         buf_q <= buf_shift_c;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      data_nxt    = m_data;
      valid_nxt   = m_valid;
      index_nxt   = m_index;
      last_nxt    = m_last;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      overrun_nxt = overrun;
      load_c      = 1'b0;
      shift_c     = 1'b0;

      unique case (state)
         S_IDLE: begin
            index_nxt = '0;
            if (start_c) begin
               state_nxt = S_STREAM;
               load_c    = 1'b1;
               data_nxt  = flatten_conv_result[SAMPLE_W-1:0];
               valid_nxt = 1'b1;
               last_nxt  = 1'(N_OUT == 1);
               busy_nxt  = 1'b1;
            end
         end
         S_STREAM: begin
            if (start_c) begin
               overrun_nxt = 1'b1;
            end
            if (xfer_c) begin
               if (m_last) begin
                  state_nxt = S_DONE;
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  shift_c   = 1'b1;
                  data_nxt  = buf_shift_c[SAMPLE_W-1:0];
                  index_nxt = m_index + IDX_W'(1);
                  last_nxt  = ((m_index + IDX_W'(1)) == LAST_IDX);
               end
            end
         end
         S_DONE: begin
            // A completion edge here is dropped; the source must re-raise it.
            if (start_c) begin
               overrun_nxt = 1'b1;
            end
            state_nxt = S_IDLE;
            index_nxt = '0;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: a 4-sample instance for handshake and corner
// cases, and a default-sized instance for the full-length stream.
module tb_conv_result_streamer;

   localparam int unsigned NS = 4;
   localparam int unsigned NL = 2420;
   localparam int unsigned IW = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            ic_s, rdy_s;
   logic [NS*16:0]  bus_s;
   logic [15:0]     data_s;
   logic            valid_s, last_s, busy_s, done_s, ovr_s;
   logic [IW-1:0]   idx_s;

   logic            ic_l, rdy_l;
   logic [NL*16:0]  bus_l;
   logic [15:0]     data_l;
   logic            valid_l, last_l, busy_l, done_l, ovr_l;
   logic [IW-1:0]   idx_l;

   conv_result_streamer #(.LEN(1), .SIGNAL_LENGTH_1(2), .IDX_W(IW)) dut_s (
      .clk(clk), .rst_n(rst_n), .is_completed(ic_s), .flatten_conv_result(bus_s),
      .m_data(data_s), .m_valid(valid_s), .m_ready(rdy_s), .m_index(idx_s),
      .m_last(last_s), .busy(busy_s), .done(done_s), .overrun(ovr_s)
   );

   conv_result_streamer #(.LEN(19), .SIGNAL_LENGTH_1(2400), .IDX_W(IW)) dut_l (
      .clk(clk), .rst_n(rst_n), .is_completed(ic_l), .flatten_conv_result(bus_l),
      .m_data(data_l), .m_valid(valid_l), .m_ready(rdy_l), .m_index(idx_l),
      .m_last(last_l), .busy(busy_l), .done(done_l), .overrun(ovr_l)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] exp_s [NS];
   logic [NS*16:0] base_bus;

   typedef struct {
      logic        ic;
      logic        rdy;
      logic        valid;
      logic [15:0] data;
      int          idx;
      logic        last;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(logic ic, logic rdy, logic valid, logic [15:0] data,
                               int idx, logic last, logic busy, logic done);
      vec_t v;
      v.ic = ic; v.rdy = rdy; v.valid = valid; v.data = data;
      v.idx = idx; v.last = last; v.busy = busy; v.done = done;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected stream is whatever the bus held when the start edge was driven.
   task automatic snap_small();
      for (int i = 0; i < int'(NS); i++) exp_s[i] = bus_s[i*16 +: 16];
   endtask

   // Model of one stream: sample k is presented until accepted, then k+1;
   // after the last acceptance comes one done cycle, then idle.
   task automatic drain(input int start_acc, input int rdy_pct, input bit scribble,
                        input logic exp_ovr);
      int acc = start_acc;
      int guard = 0;
      logic r;
      while (acc < int'(NS) && guard < 200) begin
         chk("valid", 32'(valid_s), 32'd1);
         chk("data", 32'(data_s), 32'(exp_s[acc]));
         chk("index", 32'(idx_s), 32'(acc));
         chk("last", 32'(last_s), 32'(acc == int'(NS) - 1));
         chk("busy", 32'(busy_s), 32'd1);
         chk("overrun", 32'(ovr_s), 32'(exp_ovr));
         r = (int'($urandom_range(99)) < rdy_pct);
         rdy_s = r;
         if (scribble) bus_s = {$urandom, $urandom, $urandom};
         @(posedge clk);
         if (r) acc++;
         @(negedge clk);
         guard++;
      end
      chk("drain_bound", 32'(guard < 200), 32'd1);
      chk("done_pulse", 32'(done_s), 32'd1);
      chk("done_valid", 32'(valid_s), 32'd0);
      chk("done_busy", 32'(busy_s), 32'd0);
      cyc();
      chk("done_clear", 32'(done_s), 32'd0);
      chk("idle_index", 32'(idx_s), 32'd0);
      chk("idle_valid", 32'(valid_s), 32'd0);
      chk("idle_overrun", 32'(ovr_s), 32'(exp_ovr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      base_bus = {1'b1, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0001};
      rst_n = 1'b0;
      ic_s = 1'b0; rdy_s = 1'b0; bus_s = base_bus;
      ic_l = 1'b0; rdy_l = 1'b0; bus_l = '0;
      repeat (3) @(negedge clk);

      chk("rst_valid", 32'(valid_s), 32'd0);
      chk("rst_data", 32'(data_s), 32'd0);
      chk("rst_index", 32'(idx_s), 32'd0);
      chk("rst_last", 32'(last_s), 32'd0);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_done", 32'(done_s), 32'd0);
      chk("rst_overrun", 32'(ovr_s), 32'd0);
      chk("rst_valid_l", 32'(valid_l), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Full-rate stream, then backpressure pattern 1,0,0,1,1,0,1,1.
      tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 1, 16'h0001, 0, 0, 1, 0);
      tbl[2]  = mk(1, 1, 1, 16'hFFFE, 1, 0, 1, 0);
      tbl[3]  = mk(1, 1, 1, 16'h7FFF, 2, 0, 1, 0);
      tbl[4]  = mk(0, 1, 1, 16'h8000, 3, 1, 1, 0);
      tbl[5]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 1);
      tbl[6]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0);
      tbl[7]  = mk(1, 1, 0, 16'h0000, 0, 0, 0, 0);
      tbl[8]  = mk(1, 1, 1, 16'h0001, 0, 0, 1, 0);
      tbl[9]  = mk(1, 0, 1, 16'hFFFE, 1, 0, 1, 0);
      tbl[10] = mk(1, 0, 1, 16'hFFFE, 1, 0, 1, 0);
      tbl[11] = mk(1, 1, 1, 16'hFFFE, 1, 0, 1, 0);
      tbl[12] = mk(1, 1, 1, 16'h7FFF, 2, 0, 1, 0);
      tbl[13] = mk(1, 0, 1, 16'h8000, 3, 1, 1, 0);
      tbl[14] = mk(0, 1, 1, 16'h8000, 3, 1, 1, 0);
      tbl[15] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 1);
      tbl[16] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         chk("tbl_valid", 32'(valid_s), 32'(tbl[i].valid));
         chk("tbl_last", 32'(last_s), 32'(tbl[i].last));
         chk("tbl_busy", 32'(busy_s), 32'(tbl[i].busy));
         chk("tbl_done", 32'(done_s), 32'(tbl[i].done));
         chk("tbl_overrun", 32'(ovr_s), 32'd0);
         if (tbl[i].valid) chk("tbl_data", 32'(data_s), 32'(tbl[i].data));
         if (tbl[i].valid || (!tbl[i].busy && !tbl[i].done))
            chk("tbl_index", 32'(idx_s), 32'(tbl[i].idx));
         ic_s = tbl[i].ic;
         rdy_s = tbl[i].rdy;
         cyc();
      end

      // Capture isolation: bus scribbled after capture, is_completed held high.
      bus_s = base_bus; snap_small();
      ic_s = 1'b1; rdy_s = 1'b1;
      cyc();
      drain(0, 100, 1'b1, 1'b0);
      repeat (14) begin
         cyc();
         chk("hold_no_retrig", 32'(valid_s), 32'd0);
         chk("hold_overrun", 32'(ovr_s), 32'd0);
      end

      // Randomized data, gaps and backpressure against the stream model.
      for (int it = 0; it < 20; it++) begin
         ic_s = 1'b0;
         repeat ($urandom_range(1, 4)) begin
            cyc();
            chk("gap_valid", 32'(valid_s), 32'd0);
         end
         for (int k = 0; k < int'(NS); k++) bus_s[k*16 +: 16] = 16'($urandom);
         bus_s[NS*16] = 1'($urandom);
         snap_small();
         ic_s = 1'b1;
         rdy_s = 1'($urandom);
         cyc();
         drain(0, int'($urandom_range(30, 100)), 1'($urandom), 1'b0);
      end

      // Second completion edge while streaming at index 1.
      ic_s = 1'b0; bus_s = base_bus; snap_small();
      cyc();
      ic_s = 1'b1; rdy_s = 1'b1;
      cyc();
      chk("ovr_idx0", 32'(idx_s), 32'd0);
      cyc();
      chk("ovr_idx1", 32'(idx_s), 32'd1);
      rdy_s = 1'b0; ic_s = 1'b0;
      cyc();
      chk("ovr_before", 32'(ovr_s), 32'd0);
      ic_s = 1'b1;
      cyc();
      chk("ovr_set", 32'(ovr_s), 32'd1);
      chk("ovr_hold_idx", 32'(idx_s), 32'd1);
      chk("ovr_hold_data", 32'(data_s), 32'hFFFE);
      drain(1, 60, 1'b0, 1'b1);
      ic_s = 1'b0;
      cyc();
      ic_s = 1'b1;
      cyc();
      drain(0, 100, 1'b0, 1'b1);

      // Asynchronous reset at index 2, released with is_completed still high.
      ic_s = 1'b0;
      cyc();
      ic_s = 1'b1; rdy_s = 1'b1;
      repeat (3) cyc();
      chk("rst_mid_idx2", 32'(idx_s), 32'd2);
      rdy_s = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_s), 32'd0);
      chk("arst_busy", 32'(busy_s), 32'd0);
      chk("arst_index", 32'(idx_s), 32'd0);
      chk("arst_overrun", 32'(ovr_s), 32'd0);
      repeat (3) begin
         cyc();
         chk("arst_no_done", 32'(done_s), 32'd0);
      end
      rst_n = 1'b1;
      cyc();
      chk("arst_no_done_after", 32'(done_s), 32'd0);
      drain(0, 100, 1'b0, 1'b0);

      // Full-length stream on the default-sized instance.
      for (int i = 0; i < int'(NL); i++) bus_l[i*16 +: 16] = 16'(i);
      bus_l[NL*16] = 1'b1;
      rdy_l = 1'b1;
      ic_l = 1'b1;
      for (int e = 1; e <= int'(NL) + 2; e++) begin
         cyc();
         if (e <= int'(NL)) begin
            chk("big_valid", 32'(valid_l), 32'd1);
            chk("big_index", 32'(idx_l), 32'(e - 1));
            chk("big_data", 32'(data_l), 32'(16'(e - 1)));
            if (e >= int'(NL) - 1) chk("big_last", 32'(last_l), 32'(e == int'(NL)));
         end else if (e == int'(NL) + 1) begin
            chk("big_done", 32'(done_l), 32'd1);
            chk("big_done_valid", 32'(valid_l), 32'd0);
         end else begin
            chk("big_done_clear", 32'(done_l), 32'd0);
            chk("big_busy", 32'(busy_l), 32'd0);
            chk("big_overrun", 32'(ovr_l), 32'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
